// File: rtl/rx_pkg.sv
// rx_pkg: shared widths and block type for the UART receive block packer
package rx_pkg;
  localparam int BLOCK_W = 128;
  localparam int BYTE_W = 8;
  localparam int BYTES_PER_BLOCK = 16;
  localparam int FILL_W = 4;
  typedef logic [BLOCK_W-1:0] block_t;
endpackage

// File: rtl/block_fifo.sv
// block_fifo: first-word-fall-through FIFO of whole blocks, head forced to 0 when empty
module block_fifo #(
  parameter int W = 128,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);
  localparam int AW = $clog2(DEPTH);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("block_fifo DEPTH must be a power of two >= 2");
  end
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0] cnt_q;
  logic pop_ok, push_ok;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign head_o = empty_o ? '0 : mem_q[rptr_q];
  assign pop_ok = pop_i && !empty_o;
  // a pop in the same cycle frees a slot for a push into a full FIFO
  assign push_ok = push_i && (!full_o || pop_ok);
  // pointer and occupancy update; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok) rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end
  // storage write, no reset needed since empty masks the head
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= data_i;
  end
endmodule

// File: rtl/uart_rx_block_packer.sv
// uart_rx_block_packer: packs UART bytes big-endian into 128-bit blocks feeding a FWFT FIFO (optional RX_TIMEOUT_EN discards stale partial blocks)
module uart_rx_block_packer
  import rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              byte_valid,
  output logic [BLOCK_W-1:0] block_out,
  output logic              rx_empty,
  input  logic              rx_pop,
  output logic              overflow,
  input  logic              overflow_clr,
  output logic [FILL_W-1:0] fill_count,
  output logic              timeout_flush
);
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end
  block_t data_q, data_d, shifted;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic ovf_q, ovf_d;
  logic complete, full, flush;
  assign shifted = {data_q[BLOCK_W-BYTE_W-1:0], byte_in};
  assign complete = byte_valid && fill_q == FILL_W'(BYTES_PER_BLOCK - 1);
`ifdef RX_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  logic [IW-1:0] idle_q, idle_d;
  logic tf_q;
  // idle counter only runs on a stalled partial block; a byte on the limit cycle wins
  always_comb begin
    flush = fill_q != '0 && !byte_valid && idle_q == IW'(TIMEOUT_CYCLES - 1);
    idle_d = (fill_q == '0 || byte_valid || flush) ? '0 : idle_q + 1'b1;
  end
  // idle counter and one-cycle flush pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_q <= '0;
      tf_q <= 1'b0;
    end else begin
      idle_q <= idle_d;
      tf_q <= flush;
    end
  end
  assign timeout_flush = tf_q;
`else
  assign flush = 1'b0;
  assign timeout_flush = 1'b0;
`endif
  // shift bytes in from the bottom so the first byte ends up in the top lane
  always_comb begin
    data_d = byte_valid ? shifted : data_q;
    fill_d = flush ? '0 : byte_valid ? fill_q + 1'b1 : fill_q;
    ovf_d = (complete && full && !rx_pop) || (ovf_q && !overflow_clr);
  end
  // packer state and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      fill_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      data_q <= data_d;
      fill_q <= fill_d;
      ovf_q <= ovf_d;
    end
  end
  assign fill_count = fill_q;
  assign overflow = ovf_q;
  block_fifo #(.W(BLOCK_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push_i(complete),
    .data_i(shifted),
    .pop_i(rx_pop),
    .full_o(full),
    .empty_o(rx_empty),
    .head_o(block_out)
  );
endmodule

// File: tb/tb_uart_rx_block_packer.sv
// tb_uart_rx_block_packer: directed self-checking bench for the block packer
module tb_uart_rx_block_packer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] byte_in = '0;
  logic byte_valid = 1'b0;
  logic [127:0] block_out;
  logic rx_empty;
  logic rx_pop = 1'b0;
  logic overflow;
  logic overflow_clr = 1'b0;
  logic [3:0] fill_count;
  logic timeout_flush;
  int checks = 0;
  int errors = 0;

  localparam logic [127:0] BLK0 = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] BLK1 = 128'h101112131415161718191A1B1C1D1E1F;
  localparam logic [127:0] BLK2 = 128'h202122232425262728292A2B2C2D2E2F;
  localparam logic [127:0] BLK3 = 128'h303132333435363738393A3B3C3D3E3F;
  localparam logic [127:0] BLKA = 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF;
  localparam logic [127:0] BLK5 = 128'h505152535455565758595A5B5C5D5E5F;

  uart_rx_block_packer #(.FIFO_DEPTH(2), .TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
    .block_out(block_out), .rx_empty(rx_empty), .rx_pop(rx_pop),
    .overflow(overflow), .overflow_clr(overflow_clr), .fill_count(fill_count),
    .timeout_flush(timeout_flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic pop);
    byte_in = b;
    byte_valid = 1'b1;
    rx_pop = pop;
    tick();
    byte_valid = 1'b0;
    rx_pop = 1'b0;
  endtask

  task automatic send_block(input logic [7:0] base);
    for (int i = 0; i < 16; i++) send(base + 8'(i), 1'b0);
  endtask

  task automatic pop();
    rx_pop = 1'b1;
    tick();
    rx_pop = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    chk("rst_empty", 128'(rx_empty), 128'd1);
    chk("rst_block", block_out, '0);
    chk("rst_ovf", 128'(overflow), 128'd0);
    chk("rst_fill", 128'(fill_count), 128'd0);
    chk("rst_tf", 128'(timeout_flush), 128'd0);

    // test 1: spaced bytes 0x00..0x0F
    for (int i = 0; i < 15; i++) begin
      send(8'(i), 1'b0);
      tick();
      tick();
    end
    chk("t1_fill15", 128'(fill_count), 128'd15);
    chk("t1_empty_before", 128'(rx_empty), 128'd1);
    send(8'h0F, 1'b0);
    chk("t1_empty_after", 128'(rx_empty), 128'd0);
    chk("t1_block", block_out, BLK0);
    chk("t1_fill0", 128'(fill_count), 128'd0);
    pop();
    chk("t1_popped", 128'(rx_empty), 128'd1);

    // test 2: three blocks without pop overflows a depth-2 FIFO
    send_block(8'h10);
    send_block(8'h20);
    chk("t2_no_ovf_yet", 128'(overflow), 128'd0);
    send_block(8'h30);
    chk("t2_ovf", 128'(overflow), 128'd1);
    chk("t2_fill0", 128'(fill_count), 128'd0);
    chk("t2_head1", block_out, BLK1);
    pop();
    chk("t2_head2", block_out, BLK2);
    pop();
    chk("t2_empty", 128'(rx_empty), 128'd1);
    chk("t2_zero", block_out, '0);
    chk("t2_ovf_sticky", 128'(overflow), 128'd1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("t2_ovf_clr", 128'(overflow), 128'd0);

    // test 3: push while full with simultaneous pop
    send_block(8'h10);
    send_block(8'h20);
    for (int i = 0; i < 15; i++) send(8'h30 + 8'(i), 1'b0);
    send(8'h3F, 1'b1);
    chk("t3_no_ovf", 128'(overflow), 128'd0);
    chk("t3_head2", block_out, BLK2);
    pop();
    chk("t3_head3", block_out, BLK3);
    chk("t3_not_empty", 128'(rx_empty), 128'd0);
    pop();
    chk("t3_empty", 128'(rx_empty), 128'd1);

    // test 4: reset discards a partial block
    for (int i = 0; i < 7; i++) send(8'h70 + 8'(i), 1'b0);
    chk("t4_fill7", 128'(fill_count), 128'd7);
    do_reset();
    chk("t4_fill_rst", 128'(fill_count), 128'd0);
    send_block(8'hA0);
    chk("t4_block", block_out, BLKA);
    pop();

    // test 5: pop while empty is ignored
    pop();
    pop();
    chk("t5_empty", 128'(rx_empty), 128'd1);
    chk("t5_ovf", 128'(overflow), 128'd0);
    send_block(8'h50);
    chk("t5_block", block_out, BLK5);
    pop();
    chk("t5_empty_after", 128'(rx_empty), 128'd1);

    // test 5b: one held block plus simultaneous push and pop
    send_block(8'h10);
    for (int i = 0; i < 15; i++) send(8'h20 + 8'(i), 1'b0);
    send(8'h2F, 1'b1);
    chk("t5b_head", block_out, BLK2);
    chk("t5b_not_empty", 128'(rx_empty), 128'd0);
    pop();
    chk("t5b_empty", 128'(rx_empty), 128'd1);

`ifdef RX_TIMEOUT_EN
    // test 6: idle timeout flushes the partial block
    for (int i = 0; i < 5; i++) send(8'h90 + 8'(i), 1'b0);
    for (int i = 0; i < 19; i++) tick();
    chk("t6_no_flush_yet", 128'(timeout_flush), 128'd0);
    chk("t6_fill5", 128'(fill_count), 128'd5);
    tick();
    chk("t6_flush", 128'(timeout_flush), 128'd1);
    chk("t6_fill0", 128'(fill_count), 128'd0);
    tick();
    chk("t6_flush_pulse", 128'(timeout_flush), 128'd0);
    chk("t6_fifo_untouched", 128'(rx_empty), 128'd1);
    send_block(8'h50);
    chk("t6_clean_block", block_out, BLK5);
    pop();
`else
    // without the timeout a partial block waits indefinitely
    for (int i = 0; i < 5; i++) send(8'h90 + 8'(i), 1'b0);
    for (int i = 0; i < 40; i++) tick();
    chk("t6_fill_held", 128'(fill_count), 128'd5);
    chk("t6_tf_zero", 128'(timeout_flush), 128'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
